param_seq_alu: RTL

//  - Registered, handshaked ALU of parametrised width that succeeds the fixed 8-bit combinational ALU.
//  - Adds SUB, signed SLT, a multi-cycle shift-add MUL, and zero/overflow flags.
//  - Sits between an issue stage (valid/ready in) and a writeback stage (valid/ready out).

---
 rtl/alu_pkg.sv | 5 +
 rtl/shift_add_mul.sv | 42 ++++
 rtl/param_seq_alu.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by the ALU and its bench
package alu_pkg;
    typedef enum logic [2:0] {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL} alu_op_e;
    typedef enum logic {IDLE, BUSY} alu_state_e;
endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative unsigned multiplier, one multiplier bit per cycle, WIDTH cycles per product
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [2*WIDTH-1:0] mcand, acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    // latch operands on start, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            busy   <= !done;
            cnt    <= cnt + 1'b1;
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/param_seq_alu.sv
// param_seq_alu: registered valid/ready ALU; multi-cycle MUL is built only when ALU_MUL_EN is defined
module param_seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  alu_op_e          operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);
    logic             accept, arith, slt, load;
    logic [WIDTH-1:0] bb, c_res, l_res;
    logic [WIDTH:0]   sum;
    logic             c_cout, c_ovf, l_cout, l_ovf;
    assign accept = in_valid && in_ready;
    assign arith  = (operation == OP_ADD) || (operation == OP_SUB);
    assign bb     = (operation == OP_SUB) ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, carry_in};
    assign slt    = $signed(a) < $signed(b);
    // single-cycle result and flags; opcodes with no function here yield zero
    always_comb begin
        c_res  = (operation == OP_AND) ? (a & b) :
                 (operation == OP_OR)  ? (a | b) :
                 arith                 ? sum[WIDTH-1:0] :
                 (operation == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt} : '0;
        c_cout = arith && sum[WIDTH];
        c_ovf  = arith && (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
`ifdef ALU_MUL_EN
    alu_state_e         state, state_nxt;
    logic               is_mul, mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] product;
    assign is_mul    = operation == OP_MUL;
    assign mul_start = accept && is_mul;
    assign in_ready  = (state == IDLE) && !mul_busy && (!out_valid || out_ready);
    assign load      = (accept && !is_mul) || mul_done;
    assign l_res     = mul_done ? product[WIDTH-1:0] : c_res;
    assign l_cout    = mul_done ? |product[2*WIDTH-1:WIDTH] : c_cout;
    assign l_ovf     = !mul_done && c_ovf;
    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );
    // state register; reset discards any multiply in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // enter BUSY on an accepted MUL, return when the last multiplier bit is consumed
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && mul_start) ? BUSY :
                    (state == BUSY && mul_done)  ? IDLE : state;
    end
`else
    assign in_ready = !out_valid || out_ready;
    assign load     = accept;
    assign l_res    = c_res;
    assign l_cout   = c_cout;
    assign l_ovf    = c_ovf;
`endif
    // output register: load wins over pop so back-to-back transfers keep out_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= l_res;
            carry_out <= l_cout;
            zero      <= (l_res == '0);
            overflow  <= l_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
